// File: rtl/roach_opb_master_access.sv
// roach_opb_master_access: single-outstanding OPB master that turns user requests into OPB transfers
// with errAck/xferAck/retry/timeout/watchdog handling and a one-cycle completion strobe.
`timescale 1ns/1ps
module roach_opb_master_access #(
    parameter int C_OPB_AWIDTH = 32,
    parameter int C_OPB_DWIDTH = 32,
    parameter int C_MAX_RETRY  = 4,
    parameter int C_WATCHDOG   = 255
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_rnw,
    input  logic [C_OPB_AWIDTH-1:0]   req_addr,
    input  logic [C_OPB_DWIDTH-1:0]   req_data,
    input  logic [C_OPB_DWIDTH/8-1:0] req_be,
    output logic                      rsp_valid,
    output logic [C_OPB_DWIDTH-1:0]   rsp_data,
    output logic [1:0]                rsp_code,
    output logic                      M_request,
    output logic                      M_select,
    output logic                      M_RNW,
    output logic [0:C_OPB_AWIDTH-1]   M_ABus,
    output logic [0:C_OPB_DWIDTH/8-1] M_BE,
    output logic [0:C_OPB_DWIDTH-1]   M_DBus,
    output logic                      M_seqAddr,
    output logic                      M_busLock,
    input  logic                      OPB_MGrant,
    input  logic                      OPB_xferAck,
    input  logic                      OPB_errAck,
    input  logic                      OPB_retry,
    input  logic                      OPB_timeout,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus
);
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
    state_t                    state_q, state_d;
    logic                      rnw_q, rnw_d;
    logic [C_OPB_AWIDTH-1:0]   addr_q, addr_d;
    logic [C_OPB_DWIDTH-1:0]   data_q, data_d, rdata_q, rdata_d;
    logic [C_OPB_DWIDTH/8-1:0] be_q, be_d;
    logic [3:0]                retry_q, retry_d;
    logic [15:0]               wd_q, wd_d;
    logic [1:0]                code_q, code_d;

    always_comb begin
        state_d = state_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        retry_d = retry_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        code_d  = code_q;
        case (state_q)
            IDLE: if (req_valid) begin
                rnw_d   = req_rnw;
                addr_d  = req_addr;
                data_d  = req_data;
                be_d    = req_be;
                retry_d = '0;
                wd_d    = '0;
                state_d = REQ;
            end
            REQ: if (OPB_MGrant) begin
                wd_d    = '0;
                state_d = XFER;
            end
            XFER: begin
                // Bus range vectors map by position, so numeric value is preserved.
                if (OPB_errAck) begin
                    rdata_d = '0;
                    code_d  = 2'b01;
                    state_d = DONE;
                end else if (OPB_xferAck) begin
                    rdata_d = rnw_q ? OPB_DBus : '0;
                    code_d  = 2'b00;
                    state_d = DONE;
                end else if (OPB_retry) begin
                    retry_d = retry_q + 4'd1;
                    if (retry_d == 4'(C_MAX_RETRY)) begin
                        rdata_d = '0;
                        code_d  = 2'b11;
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end else if (OPB_timeout || wd_q == 16'(C_WATCHDOG - 1)) begin
                    rdata_d = '0;
                    code_d  = 2'b10;
                    state_d = DONE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q <= IDLE;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            retry_q <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            retry_q <= retry_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        req_ready = state_q == IDLE;
        rsp_valid = state_q == DONE;
        M_request = state_q == REQ;
        M_select  = state_q == XFER;
        M_RNW     = M_select & rnw_q;
        M_ABus    = M_select ? addr_q : '0;
        M_BE      = M_select ? be_q : '0;
        M_DBus    = (M_select && !rnw_q) ? data_q : '0;
        M_seqAddr = 1'b0;
        M_busLock = 1'b0;
        rsp_data  = rdata_q;
        rsp_code  = code_q;
    end
endmodule

// File: tb/tb_roach_opb_master_access.sv
// tb_roach_opb_master_access: directed self-checking bench for the OPB master access block.
`timescale 1ns/1ps
module tb_roach_opb_master_access;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_rnw = 1'b0;
    logic [31:0] req_addr = '0, req_data = '0, rsp_data;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_code;
    logic        m_request, m_select, m_rnw, m_seqaddr, m_buslock;
    logic [0:31] m_abus, m_dbus;
    logic [0:3]  m_be;
    logic        mgrant = 1'b0, xferack = 1'b0, errack = 1'b0, retry = 1'b0, opb_timeout = 1'b0;
    logic [0:31] opb_dbus = '0;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    roach_opb_master_access #(.C_MAX_RETRY(4), .C_WATCHDOG(8)) dut (
        .OPB_Clk(clk), .OPB_Rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_code(rsp_code),
        .M_request(m_request), .M_select(m_select), .M_RNW(m_rnw),
        .M_ABus(m_abus), .M_BE(m_be), .M_DBus(m_dbus),
        .M_seqAddr(m_seqaddr), .M_busLock(m_buslock),
        .OPB_MGrant(mgrant), .OPB_xferAck(xferack), .OPB_errAck(errack),
        .OPB_retry(retry), .OPB_timeout(opb_timeout), .OPB_DBus(opb_dbus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 ack, 1 retry always, 2 silent slave, 3 errAck+xferAck, 4 OPB_timeout on 2nd XFER cycle
    task automatic xact(input string tag, input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input int gdly, input int mode, input logic [31:0] rd,
                        input int exp_lat, input int exp_ph, input int exp_sel,
                        input logic [1:0] exp_code, input logic [31:0] exp_data);
        int c, rq, ph, sc;
        logic done, prev, bad, rdy_bad;
        logic [1:0] code;
        req_valid = 1'b1; req_rnw = rnw; req_addr = addr; req_data = data; req_be = be;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0; req_rnw = 1'b0; req_addr = '0; req_data = '0; req_be = '0;
        c = 1; rq = 0; ph = 0; sc = 0; done = 1'b0; prev = 1'b0; bad = 1'b0; rdy_bad = 1'b0;
        while (!done && c < 300) begin
            mgrant = 1'b0; xferack = 1'b0; errack = 1'b0; retry = 1'b0; opb_timeout = 1'b0; opb_dbus = '0;
            if (!m_select && (m_abus != 0 || m_be != 0 || m_rnw || m_dbus != 0)) bad = 1'b1;
            if (m_request && m_select) bad = 1'b1;
            if (rsp_valid) done = 1'b1;
            else begin
                if (req_ready) rdy_bad = 1'b1;
                if (m_request) begin
                    rq++;
                    mgrant = rq > gdly;
                end else rq = 0;
                if (m_select) begin
                    if (!prev) ph++;
                    sc++;
                    if (m_abus != addr || m_be != be || m_rnw != rnw) bad = 1'b1;
                    if (m_dbus != (rnw ? 32'd0 : data)) bad = 1'b1;
                    case (mode)
                        0: begin xferack = 1'b1; opb_dbus = rd; end
                        1: retry = 1'b1;
                        3: begin errack = 1'b1; xferack = 1'b1; opb_dbus = rd; end
                        4: opb_timeout = sc == 2;
                        default: ;
                    endcase
                end
                prev = m_select;
                tick();
                c++;
            end
        end
        mgrant = 1'b0; xferack = 1'b0; errack = 1'b0; retry = 1'b0; opb_timeout = 1'b0; opb_dbus = '0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(c), 32'(exp_lat));
        chk({tag, "_phases"}, 32'(ph), 32'(exp_ph));
        chk({tag, "_selcycles"}, 32'(sc), 32'(exp_sel));
        chk({tag, "_code"}, 32'(rsp_code), 32'(exp_code));
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_bus"}, 32'(bad), 32'd0);
        chk({tag, "_busy_ready"}, 32'(rdy_bad | req_ready), 32'd0);
        code = rsp_code;
        tick();
        chk({tag, "_strobe1"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_hold"}, {rsp_data[29:0], code}, {exp_data[29:0], exp_code});
        chk({tag, "_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_outs", 32'({rsp_valid, m_request, m_select, m_rnw, m_seqaddr, m_buslock}), 32'd0);
        chk("rst_buses", m_abus | m_dbus | 32'(m_be), 32'd0);
        chk("rst_rsp", rsp_data | 32'(rsp_code), 32'd0);
        rst = 1'b0;
        tick();
        xact("wr_basic", 1'b0, 32'h0106_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0, 3, 1, 1, 2'b00, 32'h0);
        xact("rd_gdly5", 1'b1, 32'h0106_0000, 32'h0, 4'hF, 5, 0, 32'h1234_5678, 8, 1, 1, 2'b00, 32'h1234_5678);
        xact("wr_retry", 1'b0, 32'h0000_0010, 32'h5A5A_0001, 4'h3, 0, 1, 32'h0, 9, 4, 4, 2'b11, 32'h0);
        xact("rd_wdog", 1'b1, 32'h0000_0020, 32'h0, 4'hF, 0, 2, 32'hFFFF_FFFF, 10, 1, 8, 2'b10, 32'h0);
        xact("rd_err", 1'b1, 32'h0000_0030, 32'h0, 4'hF, 0, 3, 32'hAAAA_5555, 3, 1, 1, 2'b01, 32'h0);
        xact("wr_opbto", 1'b0, 32'h0000_0040, 32'h0000_0001, 4'h1, 0, 4, 32'h0, 4, 1, 2, 2'b10, 32'h0);
        xact("rd_msb", 1'b1, 32'h8000_0004, 32'h0, 4'h6, 1, 0, 32'h8000_0001, 4, 1, 1, 2'b00, 32'h8000_0001);
        req_valid = 1'b1; req_rnw = 1'b0; req_addr = 32'h0000_0100; req_data = 32'h1111_2222; req_be = 4'hF;
        tick();
        req_valid = 1'b0;
        mgrant = 1'b1;
        tick();
        mgrant = 1'b0;
        chk("rst_xfer1_sel", 32'(m_select), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_abort_sel", 32'({m_select, m_request}), 32'd0);
        chk("rst_abort_ready", 32'(req_ready), 32'd1);
        chk("rst_abort_rsp", rsp_data | 32'(rsp_code), 32'd0);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                seen |= rsp_valid | m_select | m_request;
                tick();
            end
            chk("rst_abort_quiet", 32'(seen), 32'd0);
        end
        xact("wr_after_rst", 1'b0, 32'h0106_0000, 32'hCAFE_F00D, 4'hC, 0, 0, 32'h0, 3, 1, 1, 2'b00, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/roach_opb_master_access.md
ROACH_OPB_MASTER_ACCESS -- requirements
Module: roach_opb_master_access

Interface
REQ-001 C_OPB_AWIDTH, 32, OPB address width; only 32 SHALL be supported.
REQ-002 C_OPB_DWIDTH, 32, OPB data width; only 32 SHALL be supported.
REQ-003 C_MAX_RETRY, 4, Sl_retry count that SHALL end a request with a retry-exhausted code; legal range 1..15.
REQ-004 C_WATCHDOG, 255, XFER cycles without a slave response that SHALL end a request with a timeout code; legal range 2..65535.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset:
- OPB_Clk  in  1  clock
- OPB_Rst  in  1  synchronous reset, active-high
REQ-006 User request and response ports:
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_rnw  in  1  1 = read, 0 = write
- req_addr  in  32  byte address [31:0]
- req_data  in  32  write data [31:0]
- req_be  in  4  byte enables [3:0]
- rsp_valid  out  1  one-cycle completion strobe
- rsp_data  out  32  read data [31:0]
- rsp_code  out  2  00 ok, 01 errAck, 10 timeout, 11 retry exhausted
REQ-007 OPB master ports:
- M_request  out  1  bus request
- M_select  out  1  master select
- M_RNW  out  1  read/not-write
- M_ABus  out  [0:31]  address
- M_BE  out  [0:3]  byte enables
- M_DBus  out  [0:31]  write data
- M_seqAddr  out  1  tied 0
- M_busLock  out  1  tied 0
- OPB_MGrant  in  1  grant
- OPB_xferAck  in  1  slave acknowledge
- OPB_errAck  in  1  slave error
- OPB_retry  in  1  slave retry
- OPB_timeout  in  1  arbiter timeout
- OPB_DBus  in  [0:31]  read data
REQ-008 Vector mapping SHALL preserve numeric value: req_addr[31] to M_ABus[0], req_addr[0] to M_ABus[31]; the same rule applies to BE, DBus and rsp_data.

Function
REQ-009 The FSM SHALL have states IDLE, REQ, XFER and DONE.
REQ-010 IDLE: req_ready=1; on req_valid, the block SHALL latch rnw, addr, data and be, clear the retry and watchdog counters, and go to REQ.
REQ-011 req_ready SHALL be 0 in every state other than IDLE.
REQ-012 REQ: M_request=1; when OPB_MGrant is sampled high, the FSM SHALL go to XFER.
REQ-013 XFER: M_request=0 and M_select=1, with M_ABus, M_BE and M_RNW driven from the latched values.
REQ-014 M_DBus SHALL carry the latched write data only in XFER with rnw=0, and 0 otherwise.
REQ-015 M_ABus, M_BE and M_RNW SHALL be 0 whenever M_select=0 (OR-bus rule).
REQ-016 XFER response priority SHALL be errAck > xferAck > retry > OPB_timeout > watchdog, evaluated each cycle.
REQ-017 On xferAck, the block SHALL capture OPB_DBus into rsp_data if the access is a read (0 if a write), set code 00 and go to DONE.
REQ-018 On errAck, rsp_data SHALL be 0, code SHALL be 01, and the FSM SHALL go to DONE.
REQ-019 On retry, the block SHALL increment the retry counter; at C_MAX_RETRY it SHALL set code 11 and go to DONE, otherwise it SHALL return to REQ with M_select dropped for at least one cycle.
REQ-020 The watchdog SHALL count XFER cycles per attempt; OPB_timeout, or the watchdog reaching C_WATCHDOG-1 without a response, SHALL set code 10 and go to DONE.
REQ-021 DONE: rsp_valid=1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-022 rsp_data and rsp_code SHALL hold until the next DONE.
REQ-023 Minimum latency: with the request accepted at edge N, grant present in the first REQ cycle and xferAck in the first XFER cycle, rsp_valid SHALL be high in the cycle after edge N+2.
REQ-024 A req_valid present in DONE SHALL NOT be accepted until the following IDLE cycle.
REQ-025 At most one transfer SHALL be outstanding; there SHALL be no pipelining and no sequential-address bursts.

Reset
REQ-026 While OPB_Rst=1 at a clock edge, the block SHALL enter IDLE and clear all counters, rsp_data and rsp_code; every output SHALL be 0 except req_ready, which SHALL be 1 once out of reset.
REQ-027 A reset asserted in REQ or XFER SHALL drop M_request and M_select at that edge, with no rsp_valid for the aborted request.

Verification
REQ-028 Write 0xDEADBEEF to 0x01060000 with be=0xF, grant immediate, ack on the first XFER cycle -> M_DBus=0xDEADBEEF for one cycle; rsp_valid 3 cycles after accept; rsp_code=00; rsp_data=0.
REQ-029 Read 0x01060000 with grant delayed 5 cycles and OPB_DBus=0x12345678 at ack -> M_select rises only after grant; rsp_data=0x12345678; rsp_code=00.
REQ-030 Slave asserts retry on every attempt with C_MAX_RETRY=4 -> exactly 4 select phases, each separated by a REQ phase; rsp_code=11.
REQ-031 No slave response with C_WATCHDOG=8 -> M_select high for exactly 8 cycles; rsp_code=10; errAck and xferAck asserted together -> rsp_code=01.
REQ-032 Reset pulsed in the 2nd XFER cycle -> M_select=0 the next cycle; no rsp_valid; req_ready=1 after reset; a following write completes with code 00.
